// File: rtl/memristor_pulse_seq_pkg.sv
// Shared types for the memristor pulse sequencer: FSM states, operation
// encoding and channel helpers.
package memristor_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_GAP
    } state_t;

    typedef enum logic {
        OP_SET  = 1'b0,
        OP_READ = 1'b1
    } op_t;

    localparam logic [1:0] CH_ILLEGAL = 2'd3;

    // One-hot channel select; the illegal channel maps to no channel at all.
    function automatic logic [2:0] ch_onehot(input logic [1:0] ch);
        case (ch)
            2'd0:    ch_onehot = 3'b001;
            2'd1:    ch_onehot = 3'b010;
            2'd2:    ch_onehot = 3'b100;
            default: ch_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/memristor_pulse_seq_timer.sv
// Loadable down-counter timing every SETUP/PULSE/HOLD/GAP phase; o_zero marks
// the last cycle of the phase currently loaded.
module memristor_seq_timer #(
    parameter int CW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_value,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/memristor_pulse_seq.sv
// Command-driven SET/READ pulse-train sequencer for the three memristor
// channels' SEL/DIGITALIN inputs. All outputs are registered.
module memristor_pulse_seq
    import memristor_seq_pkg::*;
#(
    parameter int CW        = 8,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_ch,
    input  logic          cmd_op,
    input  logic [CW-1:0] cmd_width,
    input  logic [CW-1:0] cmd_count,
    input  logic [CW-1:0] cmd_gap,
    input  logic          abort,
    output logic [2:0]    sel,
    output logic [2:0]    din,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] pulses_done
);

    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYC - 1);

    state_t        r_state;
    op_t           r_op;
    logic [1:0]    r_ch;
    logic [CW-1:0] r_width;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_gap;
    logic [CW-1:0] r_pulses_done;
    logic          r_cmd_ready;
    logic [2:0]    r_sel;
    logic [2:0]    r_din;
    logic          r_busy;
    logic          r_done;
    logic          r_err;

    state_t        w_state_nxt;
    logic          w_accept;
    logic          w_finish;
    logic          w_finish_err;
    logic          w_pulse_inc;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_zero;
    op_t           w_op_eff;
    logic [2:0]    w_ch_hot;
    logic [2:0]    w_sel_nxt;
    logic [2:0]    w_din_nxt;

    memristor_seq_timer #(.CW(CW)) u_timer (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_load  (w_load),
        .i_value (w_load_val),
        .o_zero  (w_zero)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_accept     = 1'b0;
        w_finish     = 1'b0;
        w_finish_err = 1'b0;
        w_pulse_inc  = 1'b0;
        w_load       = 1'b0;
        w_load_val   = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_accept = 1'b1;
                    if (cmd_ch == CH_ILLEGAL) begin
                        w_finish     = 1'b1;
                        w_finish_err = 1'b1;
                    end else if (cmd_count == '0) begin
                        w_finish = 1'b1;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_load      = 1'b1;
                        w_load_val  = SETUP_LOAD;
                    end
                end
            end
            ST_SETUP: begin
                if (w_zero) begin
                    w_state_nxt = ST_PULSE;
                    w_load      = 1'b1;
                    w_load_val  = (r_width == '0) ? '0 : r_width - 1'b1;
                end
            end
            ST_PULSE: begin
                if (w_zero) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                    w_load_val  = HOLD_LOAD;
                    w_pulse_inc = 1'b1;
                end
            end
            ST_HOLD: begin
                // The pulse counter already includes the pulse just finished.
                if (w_zero) begin
                    if (r_pulses_done == r_count) begin
                        w_state_nxt = ST_IDLE;
                        w_finish    = 1'b1;
                    end else if (r_gap != '0) begin
                        w_state_nxt = ST_GAP;
                        w_load      = 1'b1;
                        w_load_val  = r_gap - 1'b1;
                    end else begin
                        w_state_nxt = ST_SETUP;
                        w_load      = 1'b1;
                        w_load_val  = SETUP_LOAD;
                    end
                end
            end
            ST_GAP: begin
                if (w_zero) begin
                    w_state_nxt = ST_SETUP;
                    w_load      = 1'b1;
                    w_load_val  = SETUP_LOAD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt  = ST_IDLE;
            w_finish     = 1'b1;
            w_finish_err = 1'b1;
            w_pulse_inc  = 1'b0;
            w_load       = 1'b0;
        end
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    assign w_op_eff  = w_accept ? op_t'(cmd_op) : r_op;
    assign w_ch_hot  = ch_onehot(w_accept ? cmd_ch : r_ch);
    assign w_sel_nxt = ((w_op_eff == OP_SET) &&
                        ((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_PULSE) ||
                         (w_state_nxt == ST_HOLD))) ? w_ch_hot : 3'b000;
    assign w_din_nxt = (w_state_nxt == ST_PULSE) ? w_ch_hot : 3'b000;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_SET;
            r_ch          <= '0;
            r_width       <= '0;
            r_count       <= '0;
            r_gap         <= '0;
            r_pulses_done <= '0;
            r_cmd_ready   <= 1'b1;
            r_sel         <= '0;
            r_din         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_sel       <= w_sel_nxt;
            r_din       <= w_din_nxt;
            r_done      <= w_finish;
            r_err       <= w_finish_err;
            if (w_accept) begin
                r_op          <= op_t'(cmd_op);
                r_ch          <= cmd_ch;
                r_width       <= cmd_width;
                r_count       <= cmd_count;
                r_gap         <= cmd_gap;
                r_pulses_done <= '0;
            end else if (w_pulse_inc) begin
                r_pulses_done <= r_pulses_done + 1'b1;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign sel         = r_sel;
    assign din         = r_din;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign pulses_done = r_pulses_done;

endmodule
